// File: rtl/pc_gen.sv
// Program-counter generator for the NPC fetch front end.
// Holds the fetch PC, issues valid/ready fetch requests and applies trap/redirect with fixed priority.
module pc_gen #(
    parameter int unsigned            XLEN       = 64,
    parameter logic [XLEN-1:0]        RESET_VEC  = XLEN'(64'h8000_0000),
    parameter int unsigned            INST_BYTES = 4,
    parameter int unsigned            CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              trap_valid,
    input  logic [XLEN-1:0]   trap_vec,
    input  logic              fetch_ready,
    output logic              fetch_valid,
    output logic [XLEN-1:0]   fetch_pc,
    output logic              misalign_err,
    output logic [XLEN-1:0]   bad_addr,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_cnt
);

    localparam int unsigned ALIGN_W = $clog2(INST_BYTES);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state;
    logic            handshake;
    logic            jump;
    logic [XLEN-1:0] jump_target;
    logic            jump_misaligned;

    generate
        if (INST_BYTES != 2 && INST_BYTES != 4) begin : g_bad_inst_bytes
            $error("pc_gen: INST_BYTES must be 2 or 4");
        end
        if (RESET_VEC[ALIGN_W-1:0] != '0) begin : g_bad_reset_vec
            $error("pc_gen: RESET_VEC is not aligned to INST_BYTES");
        end
    endgenerate

    assign fetch_valid = (state == RUN) && !stall;
    assign halted      = (state == HALT);
    assign handshake   = fetch_valid && fetch_ready;

    // Trap outranks redirect; both bypass stall, only the sequential advance honours it.
    always_comb begin
        jump        = 1'b0;
        jump_target = redirect_pc;
        if (trap_valid) begin
            jump        = 1'b1;
            jump_target = trap_vec;
        end else if (redirect_valid) begin
            jump        = 1'b1;
            jump_target = redirect_pc;
        end
        jump_misaligned = jump && (jump_target[ALIGN_W-1:0] != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= BOOT;
            fetch_pc     <= RESET_VEC;
            misalign_err <= 1'b0;
            bad_addr     <= '0;
            fetch_cnt    <= '0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    // An accepted request is counted even if a trap or redirect retargets the PC.
                    if (handshake && (fetch_cnt != {CNT_W{1'b1}})) begin
                        fetch_cnt <= fetch_cnt + 1'b1;
                    end
                    if (jump_misaligned) begin
                        misalign_err <= 1'b1;
                        bad_addr     <= jump_target;
                        state        <= HALT;
                    end else if (jump) begin
                        fetch_pc <= jump_target;
                    end else if (handshake) begin
                        fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed table-driven bench for pc_gen, with a second 2-bit-counter instance for saturation.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        trap_valid;
    logic [63:0] trap_vec;
    logic        fetch_ready;

    logic        fetch_valid;
    logic [63:0] fetch_pc;
    logic        misalign_err;
    logic [63:0] bad_addr;
    logic        halted;
    logic [31:0] fetch_cnt;

    logic        s_fetch_valid;
    logic [63:0] s_fetch_pc;
    logic        s_misalign_err;
    logic [63:0] s_bad_addr;
    logic        s_halted;
    logic [1:0]  s_fetch_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [63:0] rpc;
        logic        tv;
        logic [63:0] tvec;
        logic        rdy;
        logic [63:0] e_pc;
        logic        e_valid;
        logic [31:0] e_cnt;
        logic        e_halt;
        logic        e_err;
        logic [63:0] e_bad;
    } vec_t;

    vec_t vecs[$];

    pc_gen dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .trap_vec       (trap_vec),
        .fetch_ready    (fetch_ready),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .misalign_err   (misalign_err),
        .bad_addr       (bad_addr),
        .halted         (halted),
        .fetch_cnt      (fetch_cnt)
    );

    pc_gen #(.CNT_W(2)) dut_sat (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .trap_vec       (trap_vec),
        .fetch_ready    (fetch_ready),
        .fetch_valid    (s_fetch_valid),
        .fetch_pc       (s_fetch_pc),
        .misalign_err   (s_misalign_err),
        .bad_addr       (s_bad_addr),
        .halted         (s_halted),
        .fetch_cnt      (s_fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic st, input logic rv, input logic [63:0] rpc,
                           input logic tv, input logic [63:0] tvec, input logic rdy,
                           input logic [63:0] e_pc, input logic e_valid, input logic [31:0] e_cnt,
                           input logic e_halt, input logic [63:0] e_bad);
        vec_t v;
        v.stall = st;   v.rv = rv;       v.rpc = rpc;
        v.tv = tv;      v.tvec = tvec;   v.rdy = rdy;
        v.e_pc = e_pc;  v.e_valid = e_valid;  v.e_cnt = e_cnt;
        v.e_halt = e_halt;  v.e_err = e_halt;  v.e_bad = e_bad;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input vec_t v);
        stall          = v.stall;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        trap_valid     = v.tv;
        trap_vec       = v.tvec;
        fetch_ready    = v.rdy;
    endtask

    task automatic check_output(input int idx, input vec_t v);
        logic [1:0] sat;
        sat = (v.e_cnt > 3) ? 2'd3 : v.e_cnt[1:0];
        check($sformatf("v%0d pc", idx),       fetch_pc,     v.e_pc);
        check($sformatf("v%0d valid", idx),    64'(fetch_valid), 64'(v.e_valid));
        check($sformatf("v%0d cnt", idx),      64'(fetch_cnt),   64'(v.e_cnt));
        check($sformatf("v%0d halted", idx),   64'(halted),      64'(v.e_halt));
        check($sformatf("v%0d err", idx),      64'(misalign_err), 64'(v.e_err));
        check($sformatf("v%0d bad_addr", idx), bad_addr,     v.e_bad);
        check($sformatf("v%0d sat_cnt", idx),  64'(s_fetch_cnt), 64'(sat));
    endtask

    initial begin
        rst = 1'b0;
        apply_stimulus('{default: '0});
        fetch_ready = 1'b1;

        // Stall/redirect/trap/wrap/misalign scenario, expected values hand-computed.
        //      st rv rpc                     tv tvec            rdy  e_pc                     v  cnt halt bad
        add_vec(0, 0, 64'h0,                  0, 64'h0,          1,   64'h8000_0000,           1, 0,  0,   64'h0);
        add_vec(0, 0, 64'h0,                  0, 64'h0,          1,   64'h8000_0004,           1, 1,  0,   64'h0);
        add_vec(0, 0, 64'h0,                  0, 64'h0,          0,   64'h8000_0004,           1, 1,  0,   64'h0);
        add_vec(0, 0, 64'h0,                  0, 64'h0,          0,   64'h8000_0004,           1, 1,  0,   64'h0);
        add_vec(0, 0, 64'h0,                  0, 64'h0,          0,   64'h8000_0004,           1, 1,  0,   64'h0);
        add_vec(0, 0, 64'h0,                  0, 64'h0,          1,   64'h8000_0008,           1, 2,  0,   64'h0);
        add_vec(0, 0, 64'h0,                  0, 64'h0,          1,   64'h8000_000C,           1, 3,  0,   64'h0);
        add_vec(1, 1, 64'h8000_0100,          0, 64'h0,          1,   64'h8000_0100,           0, 3,  0,   64'h0);
        add_vec(1, 0, 64'h0,                  0, 64'h0,          1,   64'h8000_0100,           0, 3,  0,   64'h0);
        add_vec(0, 0, 64'h0,                  0, 64'h0,          0,   64'h8000_0100,           1, 3,  0,   64'h0);
        add_vec(0, 1, 64'h8000_0300,          1, 64'h8000_0200,  1,   64'h8000_0200,           1, 4,  0,   64'h0);
        add_vec(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0,         0,   64'hFFFF_FFFF_FFFF_FFFC, 1, 4,  0,   64'h0);
        add_vec(0, 0, 64'h0,                  0, 64'h0,          1,   64'h0,                   1, 5,  0,   64'h0);
        add_vec(0, 0, 64'h0,                  0, 64'h0,          1,   64'h4,                   1, 6,  0,   64'h0);
        add_vec(0, 1, 64'h8000_0102,          0, 64'h0,          0,   64'h4,                   0, 6,  1,   64'h8000_0102);
        add_vec(0, 1, 64'h8000_0300,          1, 64'h8000_0400,  1,   64'h4,                   0, 6,  1,   64'h8000_0102);
        add_vec(0, 0, 64'h0,                  0, 64'h0,          1,   64'h4,                   0, 6,  1,   64'h8000_0102);

        repeat (3) @(negedge clk);
        check("reset pc", fetch_pc, 64'h8000_0000);
        check("reset valid", 64'(fetch_valid), 64'h0);
        check("reset cnt", 64'(fetch_cnt), 64'h0);
        check("reset halted", 64'(halted), 64'h0);
        check("reset err", 64'(misalign_err), 64'h0);
        check("reset bad_addr", bad_addr, 64'h0);

        rst = 1'b1;
        #1;
        check("boot valid", 64'(fetch_valid), 64'h0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            @(posedge clk);
            @(negedge clk);
            check_output(i, vecs[i]);
        end

        // Asynchronous reset out of HALT, then BOOT must ignore trap/redirect.
        rst = 1'b0;
        #1;
        check("halt reset pc", fetch_pc, 64'h8000_0000);
        check("halt reset halted", 64'(halted), 64'h0);
        check("halt reset err", 64'(misalign_err), 64'h0);
        check("halt reset bad_addr", bad_addr, 64'h0);
        check("halt reset cnt", 64'(fetch_cnt), 64'h0);
        check("halt reset sat_cnt", 64'(s_fetch_cnt), 64'h0);
        @(negedge clk);
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0400;
        trap_valid     = 1'b1;
        trap_vec       = 64'h8000_0500;
        fetch_ready    = 1'b1;
        #1;
        check("boot2 valid", 64'(fetch_valid), 64'h0);
        @(posedge clk);
        @(negedge clk);
        check("boot ignores jump pc", fetch_pc, 64'h8000_0000);
        check("run valid", 64'(fetch_valid), 64'h1);

        // Misaligned trap vector with a same-cycle handshake: halt, but the accept still counts.
        redirect_valid = 1'b0;
        trap_vec       = 64'h8000_0202;
        @(posedge clk);
        @(negedge clk);
        check("trap misalign halted", 64'(halted), 64'h1);
        check("trap misalign bad_addr", bad_addr, 64'h8000_0202);
        check("trap misalign pc", fetch_pc, 64'h8000_0000);
        check("trap misalign cnt", 64'(fetch_cnt), 64'h1);
        check("trap misalign valid", 64'(fetch_valid), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
